// File: rtl/updown_sweep_controller.sv
// ---------------------------------------------------------------------------
// updown_sweep_controller
//
// Plays a programmed number of triangle sweeps lo -> hi -> lo on a WIDTH-bit
// count register and flags completion. Bounds and sweep count are latched
// when a start is accepted, so the command inputs may change during a run.
//
// Ports:
//   clk     in   1      clock, all state changes on rising edge
//   rst     in   1      synchronous, active-high reset
//   start   in   1      start command, acted on only in IDLE
//   abort   in   1      terminate active sweep (beats start and hold)
//   hold    in   1      freeze count and state while busy
//   lo      in   WIDTH  lower bound, latched on accepted start
//   hi      in   WIDTH  upper bound, latched on accepted start
//   sweeps  in   SW_W   number of full lo->hi->lo sweeps, latched on start
//   count   out  WIDTH  current count
//   dir     out  1      1 while counting up
//   busy    out  1      1 while sweeping (UP or DOWN)
//   done    out  1      one-cycle pulse on normal completion
//   err     out  1      one-cycle pulse on rejected start
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start, count holds last value
// UP    | stepping count toward latched hi
// DOWN  | stepping count toward latched lo
// DONE  | single completion cycle, done pulses, then IDLE
// ---------------------------------------------------------------------------
module updown_sweep_controller #(
    parameter int WIDTH = 5,
    parameter int SW_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [SW_W-1:0]  sweeps,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [SW_W-1:0]  rem_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             start_ok_d;

    // A run needs a non-empty range and at least one sweep.
    assign start_ok_d = (lo < hi) && (sweeps != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!abort && start) begin
                        if (start_ok_d) begin
                            lo_q    <= lo;
                            hi_q    <= hi;
                            rem_q   <= sweeps;
                            count_q <= lo;
                            state_q <= UP;
                            dir_q   <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                UP: begin
                    if (abort) begin
                        state_q <= IDLE;
                        dir_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (!hold) begin
                        if (count_q < hi_q) begin
                            count_q <= count_q + 1'b1;
                        end else begin
                            // Peak value is shown for one cycle only; turn
                            // around straight to hi-1.
                            count_q <= hi_q - 1'b1;
                            state_q <= DOWN;
                            dir_q   <= 1'b0;
                        end
                    end
                end
                DOWN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        dir_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (!hold) begin
                        if (count_q > lo_q) begin
                            count_q <= count_q - 1'b1;
                        end else if (rem_q > SW_W'(1)) begin
                            rem_q   <= rem_q - 1'b1;
                            count_q <= lo_q + 1'b1;
                            state_q <= UP;
                            dir_q   <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule
